// File: rtl/cmp_pkg.sv
// Shared definitions for the iterative comparator: op codes, relation codes,
// result codes, FSM states and small decode helpers.
package cmp_pkg;

    // ALU_FUN_CMP operation codes
    localparam logic [2:0] OP_NOP0 = 3'b000;
    localparam logic [2:0] OP_EQ   = 3'b001;
    localparam logic [2:0] OP_GT   = 3'b010;
    localparam logic [2:0] OP_LT   = 3'b011;
    localparam logic [2:0] OP_GE   = 3'b100;
    localparam logic [2:0] OP_LE   = 3'b101;
    localparam logic [2:0] OP_NE   = 3'b110;
    localparam logic [2:0] OP_NOP7 = 3'b111;

    // Raw relation codes driven on CMP_REL
    localparam logic [1:0] REL_EQ = 2'b00;
    localparam logic [1:0] REL_GT = 2'b01;
    localparam logic [1:0] REL_LT = 2'b10;

    // Result codes driven on CMP_OUT when the requested relation holds
    localparam logic [2:0] RES_FALSE = 3'd0;
    localparam logic [2:0] RES_EQ    = 3'd1;
    localparam logic [2:0] RES_GT    = 3'd2;
    localparam logic [2:0] RES_LT    = 3'd3;
    localparam logic [2:0] RES_GE    = 3'd4;
    localparam logic [2:0] RES_LE    = 3'd5;
    localparam logic [2:0] RES_NE    = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    // Both 000 and 111 complete immediately with a zero result
    function automatic logic is_nop(input logic [2:0] op);
        return (op == OP_NOP0) || (op == OP_NOP7);
    endfunction

    // Map (operation, final relation) to the result code; false gives zero
    function automatic logic [2:0] result_code(input logic [2:0] op, input logic [1:0] rel);
        logic [2:0] code;
        code = RES_FALSE;
        case (op)
            OP_EQ:   code = (rel == REL_EQ) ? RES_EQ : RES_FALSE;
            OP_GT:   code = (rel == REL_GT) ? RES_GT : RES_FALSE;
            OP_LT:   code = (rel == REL_LT) ? RES_LT : RES_FALSE;
            OP_GE:   code = (rel != REL_LT) ? RES_GE : RES_FALSE;
            OP_LE:   code = (rel != REL_GT) ? RES_LE : RES_FALSE;
            OP_NE:   code = (rel != REL_EQ) ? RES_NE : RES_FALSE;
            default: code = RES_FALSE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned magnitude compare of one operand slice.
module cmp_slice #(
    parameter int CHUNK_WIDTH = 4
) (
    input  logic [CHUNK_WIDTH-1:0] a_slice,
    input  logic [CHUNK_WIDTH-1:0] b_slice,
    output logic                   gt,
    output logic                   lt
);

    // Plain unsigned ordering; signed order is obtained upstream by MSB bias
    always_comb begin
        gt = (a_slice > b_slice);
        lt = (a_slice < b_slice);
    end

endmodule

// File: rtl/cmp_unit_iter.sv
// Iterative comparator: walks operands MSB slice first, one slice per clock,
// and stops at the first differing slice. Outputs are all registered.
module cmp_unit_iter
    import cmp_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int CHUNK_WIDTH   = 4,
    parameter int CMP_OUT_width = 3
) (
    input  logic                     CLK_CMP,
    input  logic                     RST_CMP,
    input  logic [DATA_WIDTH-1:0]    A_IN_CMP,
    input  logic [DATA_WIDTH-1:0]    B_IN_CMP,
    input  logic [2:0]               ALU_FUN_CMP,
    input  logic                     CMP_SIGNED,
    input  logic                     CMP_EN,
    output logic                     CMP_BUSY,
    output logic                     CMP_Flag,
    output logic [CMP_OUT_width-1:0] CMP_OUT,
    output logic [1:0]               CMP_REL
);

    localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0]      IDX_TOP  = IDX_W'(N - 1);
    localparam logic [DATA_WIDTH-1:0] MSB_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    cmp_state_e              state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [2:0]              op_q, op_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CMP_OUT_width-1:0] out_q, out_d;
    logic [1:0]              rel_q, rel_d;
    logic                    flag_q, flag_d;
    logic                    busy_q, busy_d;

    logic [CHUNK_WIDTH-1:0]  a_slice_s;
    logic [CHUNK_WIDTH-1:0]  b_slice_s;
    logic                    slice_gt_s;
    logic                    slice_lt_s;
    logic [1:0]              rel_s;

    // Select the slice currently addressed by the index register
    always_comb begin
        a_slice_s = a_q[int'(idx_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
        b_slice_s = b_q[int'(idx_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
    end

    cmp_slice #(
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_slice (
        .a_slice (a_slice_s),
        .b_slice (b_slice_s),
        .gt      (slice_gt_s),
        .lt      (slice_lt_s)
    );

    // Next-state and next-output logic for the IDLE/RUN/DONE sequence
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        idx_d   = idx_q;
        out_d   = out_q;
        rel_d   = rel_q;
        flag_d  = 1'b0;
        busy_d  = busy_q;

        if (slice_gt_s) begin
            rel_s = REL_GT;
        end else if (slice_lt_s) begin
            rel_s = REL_LT;
        end else begin
            rel_s = REL_EQ;
        end

        case (state_q)
            IDLE: begin
                if (CMP_EN) begin
                    // Flipping both MSBs maps two's-complement order onto unsigned order
                    a_d    = CMP_SIGNED ? (A_IN_CMP ^ MSB_MASK) : A_IN_CMP;
                    b_d    = CMP_SIGNED ? (B_IN_CMP ^ MSB_MASK) : B_IN_CMP;
                    op_d   = ALU_FUN_CMP;
                    busy_d = 1'b1;
                    if (is_nop(ALU_FUN_CMP)) begin
                        idx_d   = '0;
                        out_d   = '0;
                        rel_d   = REL_EQ;
                        flag_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d   = IDX_TOP;
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // A difference decides at once; equality decides only at slice 0
                if (slice_gt_s || slice_lt_s || (idx_q == '0)) begin
                    out_d   = CMP_OUT_width'(result_code(op_q, rel_s));
                    rel_d   = rel_s;
                    flag_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, latched operands and registered outputs; reset aborts any operation
    always_ff @(posedge CLK_CMP or negedge RST_CMP) begin
        if (!RST_CMP) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'b000;
            idx_q   <= '0;
            out_q   <= '0;
            rel_q   <= REL_EQ;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            rel_q   <= rel_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
        end
    end

    assign CMP_BUSY = busy_q;
    assign CMP_Flag = flag_q;
    assign CMP_OUT  = out_q;
    assign CMP_REL  = rel_q;

endmodule
